// File: rtl/clkce_gen_pkg.sv
// Shared state encoding and default parameters for the clkce_gen clock-enable generator.
package clkce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } clkce_state_e;

  localparam int unsigned CLKCE_NCH_DEF     = 4;
  localparam int unsigned CLKCE_DIVW_DEF    = 16;
  localparam int unsigned CLKCE_DIV_RST_DEF = 0;

endpackage

// File: rtl/clkce_gen_chan.sv
// One clock-enable channel: run/stop handshake FSM, period counter and divider registers.
// Optional 2-flop run_req synchronizer selected by CLKCE_REQ_SYNC_EN.
module clkce_chan
  import clkce_pkg::*;
#(
  parameter int unsigned DIVW    = CLKCE_DIVW_DEF,
  parameter int unsigned DIV_RST = CLKCE_DIV_RST_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [DIVW-1:0] cfg_div,
  input  logic            run_req,
  output logic            run_ack,
  output logic            gate_en,
  output logic            ce_pulse
);

  localparam logic [DIVW-1:0] DIV_RST_V = DIVW'(DIV_RST);

  clkce_state_e    r_state, w_state_nxt;
  logic [DIVW-1:0] r_cnt, w_cnt_nxt;
  logic [DIVW-1:0] r_div_pend, w_div_pend_nxt;
  logic [DIVW-1:0] r_div_act, w_div_act_nxt;
  logic            w_req;
  logic            w_ce;

`ifdef CLKCE_REQ_SYNC_EN
  logic [1:0] r_req_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req_sync <= '0;
    else        r_req_sync <= {r_req_sync[0], run_req};
  end

  assign w_req = r_req_sync[1];
`else
  assign w_req = run_req;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_div_pend <= DIV_RST_V;
      r_div_act  <= DIV_RST_V;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_div_pend <= w_div_pend_nxt;
      r_div_act  <= w_div_act_nxt;
    end
  end

  assign w_ce = (r_cnt == r_div_act) && (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_div_pend_nxt = cfg_we ? cfg_div : r_div_pend;
    w_div_act_nxt  = r_div_act;
    run_ack        = (r_state == ST_RUN);
    gate_en        = (r_state != ST_IDLE);
    ce_pulse       = w_ce;

    // Taking the post-write pending value lets a write coincident with a wrap take effect there.
    if ((r_state == ST_IDLE) || w_ce) w_div_act_nxt = w_div_pend_nxt;

    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = w_ce ? '0 : r_cnt + DIVW'(1);
        if (!w_req) w_state_nxt = ST_STOPPING;
      end
      ST_STOPPING: begin
        w_cnt_nxt = w_ce ? '0 : r_cnt + DIVW'(1);
        if (w_req)     w_state_nxt = ST_RUN;
        else if (w_ce) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/clkce_gen.sv
// Multi-channel clock-enable generator: NCH independent clkce_chan instances with addressed divider writes.
// Define CLKCE_REQ_SYNC_EN to add a 2-flop synchronizer on each run_req bit.
module clkce_gen
  import clkce_pkg::*;
#(
  parameter int unsigned NCH     = CLKCE_NCH_DEF,
  parameter int unsigned DIVW    = CLKCE_DIVW_DEF,
  parameter int unsigned DIV_RST = CLKCE_DIV_RST_DEF,
  localparam int unsigned CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [DIVW-1:0] cfg_div,
  input  logic [NCH-1:0]  run_req,
  output logic [NCH-1:0]  run_ack,
  output logic [NCH-1:0]  gate_en,
  output logic [NCH-1:0]  ce_pulse
);

  logic [NCH-1:0] w_we;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // Out-of-range channel numbers match no instance, so such writes are dropped.
    assign w_we[g] = cfg_we && (cfg_ch == CHW'(g));

    clkce_chan #(
      .DIVW    (DIVW),
      .DIV_RST (DIV_RST)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_we   (w_we[g]),
      .cfg_div  (cfg_div),
      .run_req  (run_req[g]),
      .run_ack  (run_ack[g]),
      .gate_en  (gate_en[g]),
      .ce_pulse (ce_pulse[g])
    );
  end

endmodule

// File: tb/tb_clkce_gen.sv
// Directed self-checking bench for clkce_gen (5 channels, DIV_RST=2).
module tb_clkce_gen;

`ifdef CLKCE_REQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [4:0]  run_req;
  logic [4:0]  run_ack;
  logic [4:0]  gate_en;
  logic [4:0]  ce_pulse;

  int errors = 0;
  int checks = 0;

  clkce_gen #(
    .NCH     (5),
    .DIVW    (16),
    .DIV_RST (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .run_req  (run_req),
    .run_ack  (run_ack),
    .gate_en  (gate_en),
    .ce_pulse (ce_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [15:0] d);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_div = d;
    tick();
    cfg_we  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    run_req = '0;
    #1;
    chk("rst_ack",  run_ack,  5'b0);
    chk("rst_gate", gate_en,  5'b0);
    chk("rst_ce",   ce_pulse, 5'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // ch0, div=3: ack/gate from k+1, pulses every 4th cycle
    cfg_write(3'd0, 16'd3);
    run_req[0] = 1'b1;
    for (int i = 0; i < L; i++) begin
      tick();
      chk("s1_ack_lat", run_ack[0], 1'b0);
    end
    tick();
    for (int c = 1; c <= 12; c++) begin
      chk("s1_ack",  run_ack[0],  1'b1);
      chk("s1_gate", gate_en[0],  1'b1);
      chk("s1_ce",   ce_pulse[0], (c % 4) == 0);
      tick();
    end

`ifndef CLKCE_REQ_SYNC_EN
    // ch1, div=4: drop request 2 cycles after a pulse, final period completes
    cfg_write(3'd1, 16'd4);
    run_req[1] = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      chk("s2_ce", ce_pulse[1], c == 5);
      tick();
    end
    tick();
    run_req[1] = 1'b0;
    tick();
    chk("s2_ack_drop", run_ack[1],  1'b0);
    chk("s2_gate_p3",  gate_en[1],  1'b1);
    chk("s2_ce_p3",    ce_pulse[1], 1'b0);
    tick();
    chk("s2_ce_p4",    ce_pulse[1], 1'b0);
    tick();
    chk("s2_ce_last",  ce_pulse[1], 1'b1);
    chk("s2_gate_p5",  gate_en[1],  1'b1);
    tick();
    chk("s2_gate_off", gate_en[1],  1'b0);
    chk("s2_ce_p6",    ce_pulse[1], 1'b0);
    chk("s2_ack_p6",   run_ack[1],  1'b0);

    // ch2, div=5 then div=1 mid-period, then div=2 written on a wrap cycle
    cfg_write(3'd2, 16'd5);
    run_req[2] = 1'b1;
    tick();
    for (int c = 1; c <= 24; c++) begin
      chk("s3_ce", ce_pulse[2],
          (c == 6) || (c == 12) || (c == 14) || (c == 16) || (c == 18) || (c == 21) || (c == 24));
      cfg_we  = (c == 8) || (c == 18);
      cfg_ch  = 3'd2;
      cfg_div = (c == 8) ? 16'd1 : 16'd2;
      tick();
    end
    cfg_we = 1'b0;

    // ch3, div=0: pulse every running cycle, one-cycle drain
    cfg_write(3'd3, 16'd0);
    run_req[3] = 1'b1;
    tick();
    for (int c = 1; c <= 4; c++) begin
      chk("s4_ce",  ce_pulse[3], 1'b1);
      chk("s4_ack", run_ack[3],  1'b1);
      tick();
    end
    run_req[3] = 1'b0;
    chk("s4_ce_c4", ce_pulse[3], 1'b1);
    tick();
    chk("s4_ack_stop", run_ack[3],  1'b0);
    chk("s4_gate_stp", gate_en[3],  1'b1);
    chk("s4_ce_stp",   ce_pulse[3], 1'b1);
    tick();
    chk("s4_gate_off", gate_en[3],  1'b0);
    chk("s4_ce_off",   ce_pulse[3], 1'b0);

    // ch1 (div=4 kept while idle): re-request during STOPPING
    run_req[1] = 1'b1;
    tick();
    for (int c = 1; c <= 15; c++) begin
      chk("s5_ack",  run_ack[1],  c != 8);
      chk("s5_gate", gate_en[1],  1'b1);
      chk("s5_ce",   ce_pulse[1], (c == 5) || (c == 10) || (c == 15));
      run_req[1] = (c != 7);
      tick();
    end

    // Out-of-range channel writes: ch4 must still hold DIV_RST=2
    cfg_write(3'd5, 16'd7);
    cfg_write(3'd7, 16'd9);
    run_req[4] = 1'b1;
    tick();
    for (int c = 1; c <= 6; c++) begin
      chk("s6_ce", ce_pulse[4], (c == 3) || (c == 6));
      tick();
    end
`endif

    // All channels running, then asynchronous reset mid-period
    run_req = 5'b11111;
    repeat (6 + L) tick();
    chk("s7_all_gate", gate_en, 5'b11111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s7_rst_ack",  run_ack,  5'b0);
    chk("s7_rst_gate", gate_en,  5'b0);
    chk("s7_rst_ce",   ce_pulse, 5'b0);
    run_req = '0;
    tick();
    tick();
    chk("s7_hold_gate", gate_en, 5'b0);
    rst_n = 1'b1;
    tick();

    // ch0 (was div=3) and ch3 (was div=0) must restart with DIV_RST=2
    run_req = 5'b01001;
    repeat (L) tick();
    tick();
    for (int c = 1; c <= 3; c++) begin
      chk("s8_ack",   run_ack,     5'b01001);
      chk("s8_ce0",   ce_pulse[0], c == 3);
      chk("s8_ce3",   ce_pulse[3], c == 3);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkce_gen.md
# clkce_gen

Parametrised multi-channel clock-enable generator for the sound-chip clock domain. Each channel divides the system clock by a programmable ratio and produces one-cycle `ce_pulse` strobes, plus a registered `gate_en` level suitable for driving a DQCE-type clock-gate primitive. Start and stop use a per-channel request/acknowledge handshake. Stopping is deferred to a period boundary, so the final enable period is never truncated. It replaces single hard-wired DQCE gating with N independently controlled, glitch-free channels.

## Interface
- `NCH`, 4: number of channels (1–8).
- `DIVW`, 16: divider register width.
- `DIV_RST`, 0: divider value loaded at reset on all channels.
- `clk`  in  1: system clock. All logic is in this one domain.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cfg_we`  in  1: divider write strobe.
- `cfg_ch`  in  $clog2(NCH) (min 1): target channel. Writes with `cfg_ch >= NCH` are ignored.
- `cfg_div`  in  DIVW: new divider value. Period is `cfg_div+1` cycles.
- `run_req`  in  NCH: per-channel run request (level).
- `run_ack`  out  NCH: per-channel acknowledge. High while the channel is in RUN.
- `gate_en`  out  NCH: registered gate level. High in RUN and STOPPING.
- `ce_pulse`  out  NCH: one-cycle enable strobe at each period end.

## Operation
- Per-channel state machine with states IDLE, RUN and STOPPING.
  - IDLE → RUN when `run_req` is sampled high. `cnt` is cleared to 0.
  - RUN → STOPPING when `run_req` is sampled low.
  - STOPPING → RUN when `run_req` is sampled high again. `cnt` is not reset.
  - STOPPING → IDLE at the edge following a cycle with `ce_pulse` high.
- Counter behaviour:
  - `cnt` is DIVW bits and increments each cycle in RUN or STOPPING.
  - `ce_pulse = (cnt == div_act) && state != IDLE`. It is decoded from flops only.
  - On a `ce_pulse` cycle, `cnt` wraps to 0 at the next edge.
- Divider loading:
  - `cfg_we` writes `div_pend`.
  - `div_act` loads `div_pend` at any edge where the channel is IDLE or `ce_pulse` is high.
  - A write in the same cycle as a wrap is applied at that wrap. The write bypasses `div_pend`.
- `div_act = 0` gives `ce_pulse` on every cycle while RUN or STOPPING.
- Outputs:
  - `run_ack` is high in RUN.
  - `gate_en` is high in RUN or STOPPING.
  - Both are registered state decodes with no combinational path from inputs.

## Timing
- Reset, asynchronous: all channels go to IDLE, `cnt=0`, `div_act=div_pend=DIV_RST`, and `run_ack`, `gate_en`, `ce_pulse` are all 0. Reset asserted mid-period aborts immediately. There is no drain.
- Start: `run_req` high sampled at edge k gives `run_ack=gate_en=1` from cycle k+1. The first `ce_pulse` is in cycle k+1+`div_act`.
- Stop: the channel finishes the current period. `ce_pulse` is still emitted. `run_ack` drops at the edge after `run_req` is sampled low. `gate_en` drops at the edge after the final `ce_pulse`. The worst-case drain is `div_act+1` cycles.
- `run_req` pulses shorter than one cycle are not guaranteed to be seen. Software holds `run_req` until `run_ack` matches.
- Channels are independent. Simultaneous requests on all channels are serviced in the same cycle.

## Configuration
- `CLKCE_REQ_SYNC_EN`:
  - Defined: each `run_req` bit passes through a 2-flop synchronizer before the state machine. All request-to-ack and request-to-stop latencies grow by 2 cycles.
  - Undefined: `run_req` is sampled directly, and the caller guarantees it is synchronous to `clk`.

## Structure
- Package `clkce_pkg` holds:
  - the state enum (IDLE, RUN, STOPPING);
  - default `NCH`, `DIVW` and `DIV_RST` constants.
- Sub-module `clkce_chan` is one channel: state machine, `cnt`, `div_pend`/`div_act` and the optional synchronizer.
- `clkce_gen` instantiates NCH copies in a generate loop and decodes `cfg_ch` to per-channel write enables.

## Test plan
- Reset, then channel 0 with `div=3` and `run_req[0]` high at edge 10: `run_ack[0]` and `gate_en[0]` high from cycle 11, `ce_pulse[0]` in cycles 14, 18, 22.
- Channel 1 running with `div=4`, `run_req[1]` dropped 2 cycles after a pulse: `run_ack` low next cycle, one more `ce_pulse` 3 cycles later, `gate_en` low the cycle after.
- Divider write `cfg_div=1` on channel 2 mid-period while running at `div=5`: the current period stays 6 cycles, then the period is 2 cycles.
- `div=0` on channel 3: `ce_pulse` high every running cycle. Stop completes 1 cycle after `run_req` is sampled low.
- `run_req` re-asserted during STOPPING: `run_ack` returns high, `gate_en` never drops, pulse spacing is unbroken. Write with `cfg_ch=NCH`: no channel changes. With `CLKCE_REQ_SYNC_EN` defined, the first scenario's ack moves to cycle 13.
- `rst_n` low mid-period with all channels running: all outputs 0 immediately, and `div_act` returns to `DIV_RST`.
